// File: rtl/stove_button_conditioner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : stove_button_conditioner                                        |
// | Brief    : Four-key synchroniser/debouncer producing press pulse, held     |
// |            level and long-hold level; optional auto-repeat on inc/dec      |
// |            keys when STOVE_BTN_AUTOREPEAT_EN is defined.                    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module stove_button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 500_000,
    parameter int unsigned HOLD_CYCLES     = 100_000_000,
    parameter int unsigned REPEAT_DELAY    = 25_000_000,
    parameter int unsigned REPEAT_PERIOD   = 10_000_000
) (
    input  logic       clk,
    input  logic       async_nreset,
    input  logic [3:0] btn_n,
    output logic [3:0] press_pulse,
    output logic [3:0] btn_level,
    output logic [3:0] hold_level
);

    localparam int c_NUM_KEYS = 4;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_DEB_PRESS   = 2'd1,
        ST_PRESSED     = 2'd2,
        ST_DEB_RELEASE = 2'd3
    } state_t;

    logic [3:0] r_sync1;
    logic [3:0] r_sync2;

    // Synchroniser resets to the released level so no spurious press is seen.
    always_ff @(posedge clk) begin
        if (!async_nreset) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= btn_n;
            r_sync2 <= r_sync1;
        end
    end

`ifndef STOVE_BTN_AUTOREPEAT_EN
    logic [31:0] w_unused_repeat;
    assign w_unused_repeat = REPEAT_DELAY ^ REPEAT_PERIOD;
`endif

    for (genvar gi = 0; gi < c_NUM_KEYS; gi++) begin : g_chan
        state_t      r_state;
        state_t      w_state_nxt;
        logic [31:0] r_dc;
        logic [31:0] w_dc_nxt;
        logic [31:0] r_hc;
        logic [31:0] w_hc_nxt;
        logic        r_pulse;
        logic        w_press_evt;
        logic        w_rep;
        logic        w_s;

        assign w_s = ~r_sync2[gi];

        always_comb begin
            w_state_nxt = r_state;
            w_dc_nxt    = r_dc;
            w_hc_nxt    = r_hc;
            w_press_evt = 1'b0;
            case (r_state)
                ST_IDLE: begin
                    w_dc_nxt = '0;
                    w_hc_nxt = '0;
                    if (w_s) begin
                        w_state_nxt = ST_DEB_PRESS;
                        w_dc_nxt    = 32'd1;
                    end
                end
                ST_DEB_PRESS: begin
                    if (!w_s) begin
                        w_state_nxt = ST_IDLE;
                        w_dc_nxt    = '0;
                    end else if (r_dc == DEBOUNCE_CYCLES) begin
                        w_state_nxt = ST_PRESSED;
                        w_hc_nxt    = '0;
                        w_press_evt = 1'b1;
                    end else begin
                        w_dc_nxt = r_dc + 32'd1;
                    end
                end
                ST_PRESSED: begin
                    if (r_hc < HOLD_CYCLES) begin
                        w_hc_nxt = r_hc + 32'd1;
                    end
                    if (!w_s) begin
                        w_state_nxt = ST_DEB_RELEASE;
                        w_dc_nxt    = 32'd1;
                    end
                end
                ST_DEB_RELEASE: begin
                    // A bounce back to pressed resumes the hold without re-pulsing.
                    if (w_s) begin
                        w_state_nxt = ST_PRESSED;
                    end else if (r_dc == DEBOUNCE_CYCLES) begin
                        w_state_nxt = ST_IDLE;
                        w_dc_nxt    = '0;
                        w_hc_nxt    = '0;
                    end else begin
                        w_dc_nxt = r_dc + 32'd1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_dc_nxt    = '0;
                    w_hc_nxt    = '0;
                end
            endcase
        end

        always_ff @(posedge clk) begin
            if (!async_nreset) begin
                r_state <= ST_IDLE;
                r_dc    <= '0;
                r_hc    <= '0;
                r_pulse <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_dc    <= w_dc_nxt;
                r_hc    <= w_hc_nxt;
                r_pulse <= w_press_evt | w_rep;
            end
        end

`ifdef STOVE_BTN_AUTOREPEAT_EN
        if (gi == 1 || gi == 2) begin : g_rep
            // Countdown to the next repeat; loaded with the delay on the press edge.
            logic [31:0] r_rc;
            logic [31:0] w_rc_nxt;

            always_comb begin
                w_rc_nxt = r_rc;
                case (r_state)
                    ST_IDLE:      w_rc_nxt = '0;
                    ST_DEB_PRESS: w_rc_nxt = w_press_evt ? REPEAT_DELAY : '0;
                    ST_PRESSED: begin
                        if (r_rc == 32'd1) begin
                            w_rc_nxt = REPEAT_PERIOD;
                        end else if (r_rc != '0) begin
                            w_rc_nxt = r_rc - 32'd1;
                        end
                    end
                    default:      w_rc_nxt = r_rc;
                endcase
            end

            always_ff @(posedge clk) begin
                if (!async_nreset) begin
                    r_rc <= '0;
                end else begin
                    r_rc <= w_rc_nxt;
                end
            end

            assign w_rep = (r_state == ST_PRESSED) && (r_rc == 32'd1);
        end else begin : g_norep
            assign w_rep = 1'b0;
        end
`else
        assign w_rep = 1'b0;
`endif

        assign press_pulse[gi] = r_pulse;
        assign btn_level[gi]   = (r_state == ST_PRESSED) || (r_state == ST_DEB_RELEASE);
        assign hold_level[gi]  = ((r_state == ST_PRESSED) || (r_state == ST_DEB_RELEASE))
                                 && (r_hc == HOLD_CYCLES);
    end

endmodule
`default_nettype wire
